// File: rtl/cmsdk_mcu_mtx4x2_pkg.sv
//------------------------------------------------------------------------------
// cmsdk_mcu_mtx4x2_pkg
// Shared definitions for the 4x2 AHB bus matrix: HTRANS and HRESP encodings
// and the default widths of the master-ID and address-user sidebands.
// No ports (package).
//------------------------------------------------------------------------------
package cmsdk_mcu_mtx4x2_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  localparam int AUSER_WIDTH_DEF = 3;
  localparam int MID_WIDTH_DEF   = 4;

endpackage

// File: rtl/cmsdk_mcu_mtx4x2_in_stg_s3.sv
//------------------------------------------------------------------------------
// cmsdk_mcu_mtx4x2_in_stg_s3
// AHB input stage for slave port S3 of the 4x2 bus matrix. A transfer that the
// targeted output stage can take right now goes straight through; otherwise
// the address phase is parked in a holding register and the master is stalled
// until the decoder accepts it. The port's data phase is tracked so that the
// decoder's selected HREADYOUT/HRESP is returned to the master.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSELS..HAUSERS       address phase from the S3 master
//   HREADYS              system HREADY as seen by the port
//   active_dec           targeted output stage grants this port now
//   readyout_dec/resp_dec selected data-phase response from the decoder
//   sel_op..auser_op     address phase towards decoder / output stage
//   held_tran_op         the presented address phase comes from the register
//   HREADYOUTS/HRESPS    response to the S3 master
//------------------------------------------------------------------------------
module cmsdk_mcu_mtx4x2_in_stg_s3
  import cmsdk_mcu_mtx4x2_pkg::*;
#(
  parameter int AUSER_WIDTH = AUSER_WIDTH_DEF,
  parameter int MID_WIDTH   = MID_WIDTH_DEF
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSELS,
  input  logic [31:0]            HADDRS,
  input  logic [1:0]             HTRANSS,
  input  logic                   HWRITES,
  input  logic [2:0]             HSIZES,
  input  logic [2:0]             HBURSTS,
  input  logic [3:0]             HPROTS,
  input  logic [MID_WIDTH-1:0]   HMASTERS,
  input  logic                   HMASTLOCKS,
  input  logic [AUSER_WIDTH-1:0] HAUSERS,
  input  logic                   HREADYS,
  input  logic                   active_dec,
  input  logic                   readyout_dec,
  input  logic [1:0]             resp_dec,
  output logic                   sel_op,
  output logic [31:0]            addr_op,
  output logic [1:0]             trans_op,
  output logic                   write_op,
  output logic [2:0]             size_op,
  output logic [2:0]             burst_op,
  output logic [3:0]             prot_op,
  output logic [MID_WIDTH-1:0]   master_op,
  output logic                   mastlock_op,
  output logic [AUSER_WIDTH-1:0] auser_op,
  output logic                   held_tran_op,
  output logic                   HREADYOUTS,
  output logic [1:0]             HRESPS
);

  logic                   held_tran_q, held_tran_d;
  logic                   data_phase_q, data_phase_d;
  logic [31:0]            addr_q;
  logic [1:0]             trans_q;
  logic                   write_q;
  logic [2:0]             size_q;
  logic [2:0]             burst_q;
  logic [3:0]             prot_q;
  logic [MID_WIDTH-1:0]   master_q;
  logic                   mastlock_q;
  logic [AUSER_WIDTH-1:0] auser_q;

  logic new_tran;
  logic accept;
  logic load_hold;

  assign new_tran  = HSELS & HTRANSS[1] & HREADYS;
  // The decoder may take a new address phase only when this port has no
  // data phase outstanding or that data phase is completing this cycle.
  assign accept    = active_dec & (~data_phase_q | readyout_dec);
  assign load_hold = new_tran & ~accept;

  // While a transfer is held HREADYOUTS is low, so no new transfer can arrive
  // and the set and clear terms never overlap.
  always_comb begin
    held_tran_d = held_tran_q;
    if (held_tran_q && accept)
      held_tran_d = 1'b0;
    else if (load_hold)
      held_tran_d = 1'b1;
  end

  always_comb begin
    data_phase_d = data_phase_q;
    if (sel_op && trans_op[1] && accept)
      data_phase_d = 1'b1;
    else if (readyout_dec)
      data_phase_d = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      held_tran_q  <= 1'b0;
      data_phase_q <= 1'b0;
      addr_q       <= '0;
      trans_q      <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      burst_q      <= '0;
      prot_q       <= '0;
      master_q     <= '0;
      mastlock_q   <= 1'b0;
      auser_q      <= '0;
    end else begin
      held_tran_q  <= held_tran_d;
      data_phase_q <= data_phase_d;
      if (load_hold) begin
        addr_q     <= HADDRS;
        // A held SEQ beat is re-issued as the first beat at the output stage.
        trans_q    <= HTRANS_NONSEQ;
        write_q    <= HWRITES;
        size_q     <= HSIZES;
        burst_q    <= HBURSTS;
        prot_q     <= HPROTS;
        master_q   <= HMASTERS;
        mastlock_q <= HMASTLOCKS;
        auser_q    <= HAUSERS;
      end
    end
  end

  always_comb begin
    if (held_tran_q) begin
      sel_op      = 1'b1;
      addr_op     = addr_q;
      trans_op    = trans_q;
      write_op    = write_q;
      size_op     = size_q;
      burst_op    = burst_q;
      prot_op     = prot_q;
      master_op   = master_q;
      mastlock_op = mastlock_q;
      auser_op    = auser_q;
    end else begin
      sel_op      = HSELS;
      addr_op     = HADDRS;
      trans_op    = HTRANSS;
      write_op    = HWRITES;
      size_op     = HSIZES;
      burst_op    = HBURSTS;
      prot_op     = HPROTS;
      master_op   = HMASTERS;
      mastlock_op = HMASTLOCKS;
      auser_op    = HAUSERS;
    end
  end

  assign held_tran_op = held_tran_q;
  assign HREADYOUTS   = data_phase_q ? readyout_dec : ~held_tran_q;
  assign HRESPS       = data_phase_q ? resp_dec : HRESP_OKAY;

endmodule

// File: tb/tb_cmsdk_mcu_mtx4x2_in_stg_s3.sv
//------------------------------------------------------------------------------
// tb_cmsdk_mcu_mtx4x2_in_stg_s3
// Directed bench for the S3 input stage: inputs change 1 ns after the rising
// edge and outputs are sampled 1 ns later, well away from the clock edge.
//------------------------------------------------------------------------------
module tb_cmsdk_mcu_mtx4x2_in_stg_s3;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic [3:0]  HMASTERS;
  logic        HMASTLOCKS;
  logic [2:0]  HAUSERS;
  logic        HREADYS;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;
  logic        sel_op;
  logic [31:0] addr_op;
  logic [1:0]  trans_op;
  logic        write_op;
  logic [2:0]  size_op;
  logic [2:0]  burst_op;
  logic [3:0]  prot_op;
  logic [3:0]  master_op;
  logic        mastlock_op;
  logic [2:0]  auser_op;
  logic        held_tran_op;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

  int checks = 0;
  int errors = 0;

  cmsdk_mcu_mtx4x2_in_stg_s3 #(.AUSER_WIDTH(3), .MID_WIDTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS),
    .HAUSERS(HAUSERS), .HREADYS(HREADYS), .active_dec(active_dec),
    .readyout_dec(readyout_dec), .resp_dec(resp_dec), .sel_op(sel_op),
    .addr_op(addr_op), .trans_op(trans_op), .write_op(write_op),
    .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
    .master_op(master_op), .mastlock_op(mastlock_op), .auser_op(auser_op),
    .held_tran_op(held_tran_op), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_bus();
    HSELS = 1'b0; HTRANSS = 2'b00; HADDRS = 32'h0; HWRITES = 1'b0;
    HSIZES = 3'b000; HBURSTS = 3'b000; HPROTS = 4'h0; HMASTERS = 4'h0;
    HMASTLOCKS = 1'b0; HAUSERS = 3'b000; HREADYS = 1'b1;
  endtask

  initial begin
    idle_bus();
    HRESETn = 1'b0; active_dec = 1'b0; readyout_dec = 1'b1; resp_dec = 2'b00;

    // Reset state: live pass-through, ready, OKAY
    settle();
    HSELS = 1'b1;
    settle();
    chk("rst_hreadyout", HREADYOUTS, 1);
    chk("rst_hresp", HRESPS, 0);
    chk("rst_held", held_tran_op, 0);
    chk("rst_sel_live", sel_op, 1);
    HSELS = 1'b0;
    tick(); tick();
    HRESETn = 1'b1;
    tick();

    // Granted NONSEQ: passes through in the same cycle
    HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_1000;
    active_dec = 1'b1; readyout_dec = 1'b1;
    settle();
    chk("g_addr", addr_op, 32'h0000_1000);
    chk("g_trans", trans_op, 2'b10);
    chk("g_held", held_tran_op, 0);
    tick();
    idle_bus();
    settle();
    chk("g_dp_ready", HREADYOUTS, 1);
    chk("g_dp_held", held_tran_op, 0);
    tick();

    // Held NONSEQ write to 0x2000, 3 stall cycles
    active_dec = 1'b0;
    HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b1; HADDRS = 32'h0000_2000;
    settle();
    chk("h_addrcyc_ready", HREADYOUTS, 1);
    tick();
    idle_bus(); HREADYS = 1'b0; HADDRS = 32'hDEAD_0000;
    settle();
    chk("h1_held", held_tran_op, 1);
    chk("h1_ready", HREADYOUTS, 0);
    chk("h1_addr", addr_op, 32'h0000_2000);
    chk("h1_trans", trans_op, 2'b10);
    chk("h1_write", write_op, 1);
    chk("h1_sel", sel_op, 1);
    tick();
    settle();
    chk("h2_held", held_tran_op, 1);
    chk("h2_ready", HREADYOUTS, 0);
    tick();
    active_dec = 1'b1;
    settle();
    chk("h3_held", held_tran_op, 1);
    chk("h3_ready", HREADYOUTS, 0);
    tick();
    HREADYS = 1'b1;
    readyout_dec = 1'b0;
    settle();
    chk("h_rel_held", held_tran_op, 0);
    chk("h_rel_follow0", HREADYOUTS, 0);
    readyout_dec = 1'b1;
    settle();
    chk("h_rel_follow1", HREADYOUTS, 1);
    chk("h_rel_resp", HRESPS, 0);
    tick();

    // Held SEQ beat: re-issued as NONSEQ, control reproduced exactly
    active_dec = 1'b0;
    HSELS = 1'b1; HTRANSS = 2'b11; HADDRS = 32'h0000_3004; HWRITES = 1'b0;
    HSIZES = 3'b010; HBURSTS = 3'b011; HPROTS = 4'b0011; HMASTERS = 4'h5;
    HMASTLOCKS = 1'b1; HAUSERS = 3'b101;
    tick();
    idle_bus(); HREADYS = 1'b0;
    HSIZES = 3'b111; HBURSTS = 3'b111; HPROTS = 4'hF; HMASTERS = 4'hA; HAUSERS = 3'b010;
    settle();
    chk("s_held", held_tran_op, 1);
    chk("s_trans", trans_op, 2'b10);
    chk("s_addr", addr_op, 32'h0000_3004);
    chk("s_size", size_op, 3'b010);
    chk("s_burst", burst_op, 3'b011);
    chk("s_prot", prot_op, 4'b0011);
    chk("s_master", master_op, 4'h5);
    chk("s_mastlock", mastlock_op, 1);
    chk("s_auser", auser_op, 3'b101);
    active_dec = 1'b1;
    tick();
    idle_bus();
    settle();
    chk("s_rel_held", held_tran_op, 0);
    tick();

    // Data phase: two wait states then a two-cycle ERROR
    HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_0400;
    active_dec = 1'b1; readyout_dec = 1'b1; resp_dec = 2'b00;
    tick();
    idle_bus();
    readyout_dec = 1'b0; resp_dec = 2'b00;
    settle();
    chk("e_c0_ready", HREADYOUTS, 0);
    chk("e_c0_resp", HRESPS, 2'b00);
    tick();
    settle();
    chk("e_c1_ready", HREADYOUTS, 0);
    tick();
    resp_dec = 2'b01;
    settle();
    chk("e_c2_ready", HREADYOUTS, 0);
    chk("e_c2_resp", HRESPS, 2'b01);
    tick();
    readyout_dec = 1'b1;
    settle();
    chk("e_c3_ready", HREADYOUTS, 1);
    chk("e_c3_resp", HRESPS, 2'b01);
    tick();
    readyout_dec = 1'b0;
    settle();
    chk("e_after_ready", HREADYOUTS, 1);
    chk("e_after_resp", HRESPS, 2'b00);

    // IDLE with HSELS=1: pass-through, no data phase
    HSELS = 1'b1; HTRANSS = 2'b00; active_dec = 1'b1;
    settle();
    chk("i_sel", sel_op, 1);
    chk("i_trans", trans_op, 2'b00);
    chk("i_ready", HREADYOUTS, 1);
    chk("i_resp", HRESPS, 2'b00);
    tick();
    settle();
    chk("i_nodp_ready", HREADYOUTS, 1);
    chk("i_nodp_resp", HRESPS, 2'b00);
    resp_dec = 2'b00; readyout_dec = 1'b1;

    // Reset while a transfer is held
    active_dec = 1'b0;
    HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_4000;
    tick();
    idle_bus(); HREADYS = 1'b0;
    settle();
    chk("r_pre_held", held_tran_op, 1);
    HRESETn = 1'b0;
    HADDRS = 32'h0000_5000;
    settle();
    chk("r_held", held_tran_op, 0);
    chk("r_ready", HREADYOUTS, 1);
    chk("r_resp", HRESPS, 2'b00);
    chk("r_sel_live", sel_op, 0);
    chk("r_addr_live", addr_op, 32'h0000_5000);
    tick();
    HRESETn = 1'b1; HREADYS = 1'b1;
    tick();
    HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h0000_6000;
    active_dec = 1'b1; readyout_dec = 1'b1;
    settle();
    chk("r_g_addr", addr_op, 32'h0000_6000);
    chk("r_g_held", held_tran_op, 0);
    tick();
    idle_bus();
    settle();
    chk("r_g_ready", HREADYOUTS, 1);
    chk("r_g_held2", held_tran_op, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmsdk_mcu_mtx4x2_in_stg_s3.md
Name: cmsdk_mcu_mtx4x2_in_stg_S3

Overview:
AHB input stage for slave port S3 of the 4x2 bus matrix. It sits between the external master on S3 and the S3 matrix decoder.
- Passes the live address phase straight through when the targeted output stage grants the port.
- Otherwise captures the address phase in a holding register and stalls the master until the held transfer is issued.
- Tracks the port's data phase and returns HREADYOUTS/HRESPS from the decoder's selected response.

Parameters:
AUSER_WIDTH, 3, width of HAUSERS/auser_op.
MID_WIDTH, 4, width of HMASTERS/master_op.

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  reset, asynchronous, active-low
HSELS  in  1  port select
HADDRS  in  32  address
HTRANSS  in  2  transfer type
HWRITES  in  1  write
HSIZES  in  3  size
HBURSTS  in  3  burst
HPROTS  in  4  protection
HMASTERS  in  MID_WIDTH  master ID
HMASTLOCKS  in  1  locked
HAUSERS  in  AUSER_WIDTH  address user
HREADYS  in  1  system HREADY seen by the port
active_dec  in  1  decoder: the targeted output stage grants this port now
readyout_dec  in  1  decoder: selected HREADYOUT
resp_dec  in  2  decoder: selected HRESP
sel_op  out  1  select to decoder
addr_op  out  32  address to decoder (decoder uses [31:10])
trans_op  out  2  HTRANS to decoder
write_op, size_op(3), burst_op(3), prot_op(4), master_op(MID_WIDTH), mastlock_op(1), auser_op(AUSER_WIDTH)  out  -  control to decoder and output stage
held_tran_op  out  1  a held transfer is being presented
HREADYOUTS  out  1  ready to master
HRESPS  out  2  response to master

Behaviour:
- new_tran = HSELS & HTRANSS[1] & HREADYS.
- accept = active_dec & (~data_phase | readyout_dec).
- Holding register: captures all address/control fields on the edge where new_tran is high and accept is low.
  - trans is stored as NONSEQ (2'b10), since a SEQ beat is re-issued as the first beat of the output stage.
  - The register is not loaded otherwise.
- held_tran, set/clear at the clock edge:
  - set when new_tran & ~accept;
  - cleared when held_tran & accept.
  - Set and clear cannot coincide: HREADYOUTS is 0 while a transfer is held, so new_tran is 0.
- Output mux:
  - held_tran=1: all *_op come from the register; sel_op=1.
  - held_tran=0: all *_op are the live inputs; sel_op=HSELS.
  - held_tran_op = held_tran.
- data_phase register:
  - set at the edge where sel_op & trans_op[1] & accept;
  - else cleared at the edge where readyout_dec=1.
- HREADYOUTS = data_phase ? readyout_dec : ~held_tran.
- HRESPS = data_phase ? resp_dec : 2'b00 (OKAY).
- Latency:
  - Granted live transfer: 0 added cycles.
  - Held transfer: at least 1 stall cycle, ending at the edge after accept.
- IDLE/BUSY, or HSELS=0: pass-through; nothing is held and data_phase is not set; the master sees a zero-wait OKAY unless a data phase is pending.
- ERROR: the 2-cycle response from resp_dec/readyout_dec is forwarded unmodified. A transfer held during the ERROR's second cycle is still issued (master-side cancellation is the master's duty).
- Reset (async, any time): held_tran=0, data_phase=0, holding register=0.
  - Resulting outputs: HREADYOUTS=1, HRESPS=OKAY, sel_op=HSELS (live).
  - A reset asserted mid-hold discards the held transfer.

Decomposition:
- Shared package cmsdk_mcu_mtx4x2_pkg: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HRESP codes (OKAY/ERROR/RETRY/SPLIT), AUSER/MID width defaults.
- Single flat module; the holding register is simple enough that no sub-module is needed.

Test Plan:
- Granted NONSEQ, active_dec=1, HADDRS=0x0000_1000, readyout_dec=1 -> addr_op=0x0000_1000 the same cycle; HREADYOUTS=1 next cycle; held_tran_op never 1.
- NONSEQ write to 0x0000_2000 with active_dec=0 for 3 cycles, then 1 -> held_tran_op=1 and HREADYOUTS=0 for 3 cycles; addr_op=0x0000_2000, trans_op=2'b10 while held; released at the edge after accept; HREADYOUTS then follows readyout_dec.
- SEQ beat (HTRANSS=2'b11) held -> trans_op=2'b10 while held; HBURSTS/HSIZES reproduced exactly.
- Data phase with readyout_dec low 2 cycles, then ERROR (resp_dec=01: ready 0 then 1) -> HREADYOUTS 0,0,0,1; HRESPS 01 on the last two cycles.
- IDLE with HSELS=1 -> sel_op=1, trans_op=00, data_phase stays 0, HREADYOUTS=1, HRESPS=00.
- HRESETn pulsed low while held_tran=1 -> immediately held_tran_op=0, HREADYOUTS=1, HRESPS=00; after release the first NONSEQ behaves as in the granted case.
